// File: rtl/ysyx_23060059_repl_policy_if.sv
// Cache <-> replacement-policy port bundle: update strobes, flush control and victim query.
// Perf counters are present only when YSYX_23060059_REPL_PERF_EN is defined.
interface ysyx_23060059_repl_policy_if #(
  parameter int NSET  = 32,
  parameter int NWAY  = 8,
  parameter int IDX_W = $clog2(NSET),
  parameter int WAY_W = $clog2(NWAY)
);
  logic [IDX_W-1:0] idx;
  logic [WAY_W-1:0] way;
  logic             access;
  logic             invalid;
  logic             flush;
  logic             busy;
  logic             req_valid;
  logic [IDX_W-1:0] req_idx;
  logic             req_ready;
  logic             vic_valid;
  logic [WAY_W-1:0] vic_way;
  logic             vic_free;
`ifdef YSYX_23060059_REPL_PERF_EN
  logic [31:0]      hit_cnt;
  logic [31:0]      evict_cnt;
`endif

  modport master (
    output idx, way, access, invalid, flush, req_valid, req_idx,
`ifdef YSYX_23060059_REPL_PERF_EN
    input  hit_cnt, evict_cnt,
`endif
    input  busy, req_ready, vic_valid, vic_way, vic_free
  );

  modport slave (
    input  idx, way, access, invalid, flush, req_valid, req_idx,
`ifdef YSYX_23060059_REPL_PERF_EN
    output hit_cnt, evict_cnt,
`endif
    output busy, req_ready, vic_valid, vic_way, vic_free
  );
endinterface

// File: rtl/ysyx_23060059_repl_policy.sv
// Replacement-policy unit: per-way valid bit plus exact rank permutation per set (LRU or FIFO),
// registered victim query and multi-cycle flush sweep. Optional counters: YSYX_23060059_REPL_PERF_EN.
module ysyx_23060059_repl_policy #(
  parameter int NSET   = 32,
  parameter int NWAY   = 8,
  parameter int POLICY = 0,
  parameter int IDX_W  = $clog2(NSET),
  parameter int WAY_W  = $clog2(NWAY)
) (
  input  logic                        clock,
  input  logic                        reset,
  ysyx_23060059_repl_policy_if.slave  bus
);

  typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] sweep_q, sweep_d;

  logic [NWAY-1:0]  v_q [NSET];
  logic [WAY_W-1:0] r_q [NSET][NWAY];

  logic             idle, do_access, do_invalid, req_fire;
  logic [WAY_W-1:0] old_rank;
  logic             hit;
  logic [NWAY-1:0]  row_v_d;
  logic [WAY_W-1:0] row_r_d [NWAY];

  logic [WAY_W-1:0] free_way, rank0_way, pick_way;
  logic             pick_free;

  logic             vic_valid_q, vic_free_q;
  logic [WAY_W-1:0] vic_way_q;

  // flush beats a same-cycle update; access beats invalid
  assign idle       = (state_q == IDLE);
  assign do_access  = idle && !bus.flush && bus.access;
  assign do_invalid = idle && !bus.flush && bus.invalid && !bus.access;
  assign req_fire   = idle && bus.req_valid;

  assign bus.busy      = !idle;
  assign bus.req_ready = idle;
  assign bus.vic_valid = vic_valid_q;
  assign bus.vic_way   = vic_way_q;
  assign bus.vic_free  = vic_free_q;

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    unique case (state_q)
      IDLE: begin
        if (bus.flush) begin
          state_d = FLUSH;
          sweep_d = '0;
        end
      end
      FLUSH: begin
        sweep_d = sweep_q + IDX_W'(1);
        if (sweep_q == IDX_W'(NSET - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  // Next contents of the addressed set; ranks stay a permutation of 0..NWAY-1.
  always_comb begin
    old_rank = r_q[bus.idx][bus.way];
    hit      = v_q[bus.idx][bus.way];
    row_v_d  = v_q[bus.idx];
    for (int unsigned w = 0; w < NWAY; w++) row_r_d[w] = r_q[bus.idx][w];
    if (do_access) begin
      row_v_d[bus.way] = 1'b1;
      if (POLICY == 0 || !hit) begin
        for (int unsigned w = 0; w < NWAY; w++) begin
          if (WAY_W'(w) == bus.way)            row_r_d[w] = WAY_W'(NWAY - 1);
          else if (r_q[bus.idx][w] > old_rank) row_r_d[w] = r_q[bus.idx][w] - WAY_W'(1);
        end
      end
    end else if (do_invalid) begin
      row_v_d[bus.way] = 1'b0;
      for (int unsigned w = 0; w < NWAY; w++) begin
        if (WAY_W'(w) == bus.way)            row_r_d[w] = '0;
        else if (r_q[bus.idx][w] < old_rank) row_r_d[w] = r_q[bus.idx][w] + WAY_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned s = 0; s < NSET; s++) begin
        v_q[s] <= '0;
        for (int unsigned w = 0; w < NWAY; w++) r_q[s][w] <= WAY_W'(w);
      end
    end else if (!idle) begin
      v_q[sweep_q] <= '0;
      for (int unsigned w = 0; w < NWAY; w++) r_q[sweep_q][w] <= WAY_W'(w);
    end else if (do_access || do_invalid) begin
      v_q[bus.idx] <= row_v_d;
      for (int unsigned w = 0; w < NWAY; w++) r_q[bus.idx][w] <= row_r_d[w];
    end
  end

  // Victim from the pre-update state: lowest free way, else the rank-0 way.
  always_comb begin
    pick_free = 1'b0;
    free_way  = '0;
    rank0_way = '0;
    for (int unsigned w = 0; w < NWAY; w++) begin
      if (!v_q[bus.req_idx][w] && !pick_free) begin
        pick_free = 1'b1;
        free_way  = WAY_W'(w);
      end
      if (r_q[bus.req_idx][w] == '0) rank0_way = WAY_W'(w);
    end
    pick_way = pick_free ? free_way : rank0_way;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vic_valid_q <= 1'b0;
      vic_way_q   <= '0;
      vic_free_q  <= 1'b0;
    end else begin
      vic_valid_q <= req_fire;
      if (req_fire) begin
        vic_way_q  <= pick_way;
        vic_free_q <= pick_free;
      end
    end
  end

`ifdef YSYX_23060059_REPL_PERF_EN
  logic [31:0] hit_cnt_q, evict_cnt_q;
  assign bus.hit_cnt   = hit_cnt_q;
  assign bus.evict_cnt = evict_cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit_cnt_q   <= '0;
      evict_cnt_q <= '0;
    end else begin
      if (do_access && hit)       hit_cnt_q   <= hit_cnt_q + 32'd1;
      if (req_fire && !pick_free) evict_cnt_q <= evict_cnt_q + 32'd1;
    end
  end
`endif

endmodule
